// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
// DEFAULT_DEPTH must match the instruction memory this loader fills.
package imem_loader_pkg;

  localparam int WORD_BYTES    = 4;
  localparam int DEFAULT_DEPTH = 64;

  typedef enum logic [2:0] {
    IDLE,
    HEADER,
    DATA,
    WRITE,
    DONE,
    ERR
  } state_t;

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the loader.
// A byte transfers on a rising edge where byte_valid && byte_ready; mem_we is a one-cycle write strobe.
interface imem_loader_if;

  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;

  modport master (
    input  byte_valid, byte_data,
    output byte_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    output byte_valid, byte_data,
    input  byte_ready, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/imem_loader_byte_assembler.sv
// Packs incoming bytes MSB-first into a 32-bit word and flags the transfer that completes it.
module imem_loader_byte_assembler
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_clear,
  input  logic        i_shift,
  input  logic [7:0]  i_byte,
  output logic [31:0] o_word,
  output logic        o_word_full
);

  logic [31:0] r_shift;
  logic [1:0]  r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift <= '0;
      r_cnt   <= '0;
    end else if (i_clear) begin
      r_cnt   <= '0;
    end else if (i_shift) begin
      r_shift <= {r_shift[23:0], i_byte};
      r_cnt   <= r_cnt + 2'd1;
    end
  end

  // High during the transfer of the last byte; the full word is in r_shift on the next cycle.
  assign o_word_full = i_shift && (r_cnt == 2'(WORD_BYTES - 1));
  assign o_word      = r_shift;

endmodule

// File: rtl/imem_loader.sv
// Loads a length-prefixed byte stream into instruction memory as 32-bit words,
// holding the CPU in reset until a load completes.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int          DEPTH     = DEFAULT_DEPTH,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_start,
  imem_loader_if.master            bus,
  output logic                     o_cpu_hold,
  output logic                     o_busy,
  output logic                     o_done,
  output logic                     o_error,
  output logic [$clog2(DEPTH):0]   o_words_loaded,
  output state_t                   o_state
);

  localparam int          CNT_W   = $clog2(DEPTH) + 1;
  localparam logic [31:0] DEPTH_U = 32'(DEPTH);

  state_t             r_state;
  logic               r_byte_ready;
  logic               r_mem_we;
  logic [31:0]        r_mem_addr;
  logic               r_cpu_hold;
  logic               r_busy;
  logic               r_done;
  logic               r_error;
  logic [CNT_W-1:0]   r_words;
  logic [7:0]         r_n;

  logic               w_xfer;
  logic               w_start_ok;
  logic               w_shift;
  logic               w_n_bad;
  logic               w_last;
  logic [CNT_W-1:0]   w_words_next;
  logic [31:0]        w_word;
  logic               w_word_full;

  assign w_xfer       = bus.byte_valid && r_byte_ready;
  assign w_start_ok   = i_start && (r_state == IDLE || r_state == DONE || r_state == ERR);
  assign w_shift      = w_xfer && (r_state == DATA);
  assign w_n_bad      = (bus.byte_data == 8'd0) || (32'(bus.byte_data) > DEPTH_U);
  assign w_words_next = r_words + 1'b1;
  assign w_last       = (32'(w_words_next) == 32'(r_n));

  imem_loader_byte_assembler u_byte_assembler (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_clear     (w_start_ok),
    .i_shift     (w_shift),
    .i_byte      (bus.byte_data),
    .o_word      (w_word),
    .o_word_full (w_word_full)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_byte_ready <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= BASE_ADDR;
      r_cpu_hold   <= 1'b1;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_error      <= 1'b0;
      r_words      <= '0;
      r_n          <= '0;
    end else begin
      r_mem_we <= 1'b0;
      case (r_state)
        IDLE, DONE, ERR: begin
          if (i_start) begin
            r_state      <= HEADER;
            r_byte_ready <= 1'b1;
            r_busy       <= 1'b1;
            r_cpu_hold   <= 1'b1;
            r_done       <= 1'b0;
            r_error      <= 1'b0;
            r_words      <= '0;
            r_mem_addr   <= BASE_ADDR;
          end
        end
        HEADER: begin
          if (w_xfer) begin
            if (w_n_bad) begin
              r_state      <= ERR;
              r_byte_ready <= 1'b0;
              r_busy       <= 1'b0;
              r_error      <= 1'b1;
            end else begin
              r_state <= DATA;
              r_n     <= bus.byte_data;
            end
          end
        end
        DATA: begin
          if (w_word_full) begin
            r_state      <= WRITE;
            r_byte_ready <= 1'b0;
            r_mem_we     <= 1'b1;
          end
        end
        WRITE: begin
          r_words    <= w_words_next;
          r_mem_addr <= r_mem_addr + 32'(WORD_BYTES);
          if (w_last) begin
            r_state    <= DONE;
            r_busy     <= 1'b0;
            r_done     <= 1'b1;
            r_cpu_hold <= 1'b0;
          end else begin
            r_state      <= DATA;
            r_byte_ready <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.byte_ready = r_byte_ready;
  assign bus.mem_we     = r_mem_we;
  assign bus.mem_addr   = r_mem_addr;
  assign bus.mem_wdata  = w_word;
  assign o_cpu_hold     = r_cpu_hold;
  assign o_busy         = r_busy;
  assign o_done         = r_done;
  assign o_error        = r_error;
  assign o_words_loaded = r_words;
  assign o_state        = r_state;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: randomized byte streams, expected writes
// derived from the stream format, and a monitor that checks every memory write.
module tb_imem_loader;
  import imem_loader_pkg::*;

  localparam int          DEPTH = 64;
  localparam logic [31:0] BASE  = 32'h0000_0000;
  localparam int          CNT_W = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic             cpu_hold;
  logic             busy;
  logic             done;
  logic             error;
  logic [CNT_W-1:0] words_loaded;
  state_t           state;

  imem_loader_if bus ();

  imem_loader #(.DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_start        (start),
    .bus            (bus),
    .o_cpu_hold     (cpu_hold),
    .o_busy         (busy),
    .o_done         (done),
    .o_error        (error),
    .o_words_loaded (words_loaded),
    .o_state        (state)
  );

  always #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          gap_max = 0;
  logic [63:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic flag(input string name, input string what);
    n_tests++;
    n_fail++;
    $display("FAIL %s: %s", name, what);
  endtask

  // Every write strobe must match the oldest outstanding expected {addr, data}.
  task automatic monitor();
    logic [63:0] e;
    forever begin
      @(negedge clk);
      if (rst_n && bus.mem_we) begin
        check("ready_in_write", 64'(bus.byte_ready), 64'd0);
        if (exp_q.size() == 0) begin
          flag("unexpected_write", $sformatf("addr %0h data %0h, none expected", bus.mem_addr, bus.mem_wdata));
        end else begin
          e = exp_q.pop_front();
          check("write_addr", 64'(bus.mem_addr), 64'(e[63:32]));
          check("write_data", 64'(bus.mem_wdata), 64'(e[31:0]));
        end
      end
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_cpu_hold"}, 64'(cpu_hold), 64'd1);
    check({tag, "_byte_ready"}, 64'(bus.byte_ready), 64'd0);
    check({tag, "_mem_we"}, 64'(bus.mem_we), 64'd0);
    check({tag, "_mem_addr"}, 64'(bus.mem_addr), 64'(BASE));
    check({tag, "_mem_wdata"}, 64'(bus.mem_wdata), 64'd0);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_done"}, 64'(done), 64'd0);
    check({tag, "_error"}, 64'(error), 64'd0);
    check({tag, "_words"}, 64'(words_loaded), 64'd0);
    check({tag, "_state"}, 64'(state), 64'(IDLE));
  endtask

  task automatic pulse_start();
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int  g;
    bit  ok;
    g  = (gap_max > 0) ? $urandom_range(0, gap_max) : 0;
    ok = 1'b0;
    repeat (g) begin
      @(posedge clk); #1;
    end
    bus.byte_valid = 1'b1;
    bus.byte_data  = b;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.byte_ready) begin
        @(posedge clk); #1;
        ok = 1'b1;
        break;
      end
    end
    bus.byte_valid = 1'b0;
    if (!ok) flag("byte_accept_timeout", $sformatf("byte %0h never accepted", b));
  endtask

  // Expected behaviour comes straight from the stream format: header N, then N big-endian words.
  task automatic run_load(input logic [7:0] s[$], input string tag, input int start_at);
    int n;
    bit legal;
    bit finished;
    n     = int'(s[0]);
    legal = (n >= 1) && (n <= DEPTH);
    if (legal) begin
      for (int i = 0; i < n; i++)
        exp_q.push_back({BASE + 32'(4 * i), s[1+4*i], s[2+4*i], s[3+4*i], s[4+4*i]});
    end
    pulse_start();
    check({tag, "_start_busy"}, 64'(busy), 64'd1);
    check({tag, "_start_hold"}, 64'(cpu_hold), 64'd1);
    check({tag, "_start_done"}, 64'(done), 64'd0);
    send_byte(s[0]);
    if (legal) begin
      for (int i = 1; i <= 4 * n; i++) begin
        if (i == start_at) pulse_start();
        send_byte(s[i]);
      end
    end
    finished = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done || error) begin
        finished = 1'b1;
        break;
      end
    end
    if (!finished) flag({tag, "_finish_timeout"}, "neither done nor error");
    check({tag, "_done"}, 64'(done), 64'(legal));
    check({tag, "_error"}, 64'(error), 64'(!legal));
    check({tag, "_cpu_hold"}, 64'(cpu_hold), 64'(!legal));
    check({tag, "_words"}, 64'(words_loaded), legal ? 64'(n) : 64'd0);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_ready_idle"}, 64'(bus.byte_ready), 64'd0);
    check({tag, "_pending"}, 64'(exp_q.size()), 64'd0);
    exp_q.delete();
  endtask

  initial begin
    logic [7:0] s[$];
    int         n;

    bus.byte_valid = 1'b0;
    bus.byte_data  = 8'h00;
    fork
      monitor();
    join_none

    repeat (3) @(posedge clk);
    #1;
    check_reset_values("rst_low");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_reset_values("rst_rel");

    s = {8'h02, 8'hE3, 8'hA0, 8'h10, 8'h05, 8'hE2, 8'h81, 8'h20, 8'h01};
    run_load(s, "two_word", -1);

    run_load('{8'h00}, "hdr_zero", -1);
    run_load('{8'h41}, "hdr_65", -1);
    s = {8'h01};
    repeat (4) s.push_back(8'($urandom_range(0, 255)));
    run_load(s, "one_word", -1);

    gap_max = 3;
    s = {8'h02, 8'hE3, 8'hA0, 8'h10, 8'h05, 8'hE2, 8'h81, 8'h20, 8'h01};
    run_load(s, "two_word_gaps", 2);

    gap_max = 0;
    s = {8'h40};
    for (int i = 0; i < DEPTH; i++) begin
      s.push_back(8'h00); s.push_back(8'h00); s.push_back(8'h00); s.push_back(8'(i));
    end
    run_load(s, "full", -1);

    for (int k = 0; k < 8; k++) begin
      gap_max = $urandom_range(0, 2);
      if ($urandom_range(0, 4) == 0) begin
        n = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(DEPTH + 1, 255);
        s = {8'(n)};
      end else begin
        n = $urandom_range(1, 8);
        s = {8'(n)};
        repeat (4 * n) s.push_back(8'($urandom_range(0, 255)));
      end
      run_load(s, $sformatf("rand%0d", k), (k % 3 == 0) ? 3 : -1);
    end

    // Reset after six data bytes: first word already written, second discarded.
    gap_max = 0;
    s = {8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    exp_q.push_back({BASE, 32'h11223344});
    pulse_start();
    foreach (s[i]) send_byte(s[i]);
    rst_n = 1'b0;
    #1;
    check_reset_values("mid_rst");
    check("mid_rst_pending", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    s = {8'h01, 8'hCA, 8'hFE, 8'hBA, 8'hBE};
    run_load(s, "after_rst", -1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
